// File: rtl/op_fetch_seq.sv
// Instruction fetch/issue sequencer: fetches 16-bit words, assembles two-word ops, handles skip and redirect.
// Optional build macro OPSEQ_IRQ_EN adds a synthetic-CALL interrupt entry (irq_req/irq_vec/irq_ack).
//
// state  | meaning
// IDLE   | one cycle after reset
// FETCH1 | fetch first word of next instruction
// FETCH2 | fetch second word of a two-word instruction
// ISSUE  | instruction presented to execute
// SKIP1  | fetch and discard first word of skipped instruction
// SKIP2  | fetch and discard second word of skipped instruction
module op_fetch_seq #(
  parameter int unsigned          PC_W     = 16,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter logic [15:0]          IRQ_BASE = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     ir,
  output logic [15:0]     ir_k,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_two,
  output logic            ir_valid,
  input  logic            ex_ready,
  input  logic            ex_skip,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc
`ifdef OPSEQ_IRQ_EN
  ,
  input  logic            irq_req,
  input  logic [4:0]      irq_vec,
  output logic            irq_ack
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    ISSUE  = 3'd3,
    SKIP1  = 3'd4,
    SKIP2  = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [PC_W-1:0] pend_pc, pend_pc_nxt;
  logic            pend, pend_nxt;
  logic            cap_w1, cap_w2;
  logic            word_two;

`ifdef OPSEQ_IRQ_EN
  localparam logic [PC_W-1:0] PC_TWO  = PC_W'(2);
  localparam logic [15:0]     CALL_OP = 16'h940E;
  logic            irq_take;
`endif

  function automatic logic is_two(input logic [15:0] w);
    return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_nxt    = pend;
    pend_pc_nxt = pend_pc;
    cap_w1      = 1'b0;
    cap_w2      = 1'b0;
    word_two    = is_two(imem_rdata);
    case (state)
      IDLE: begin
        state_nxt = FETCH1;
        if (redirect) pc_nxt = redirect_pc;
      end
      FETCH1, FETCH2, SKIP1, SKIP2: begin
        // a redirect during an outstanding request waits for the ack, then drops the data
        if (redirect || pend) begin
          if (imem_ack) begin
            pc_nxt    = redirect ? redirect_pc : pend_pc;
            pend_nxt  = 1'b0;
            state_nxt = FETCH1;
          end else begin
            pend_nxt = 1'b1;
            if (redirect) pend_pc_nxt = redirect_pc;
          end
        end else if (imem_ack) begin
          pc_nxt = pc + PC_ONE;
          case (state)
            FETCH1: begin
              cap_w1    = 1'b1;
              state_nxt = word_two ? FETCH2 : ISSUE;
            end
            FETCH2: begin
              cap_w2    = 1'b1;
              state_nxt = ISSUE;
            end
            SKIP1:   state_nxt = word_two ? SKIP2 : FETCH1;
            default: state_nxt = FETCH1;
          endcase
        end
      end
      ISSUE: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = FETCH1;
        end else if (ex_ready) begin
          state_nxt = ex_skip ? SKIP1 : FETCH1;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef OPSEQ_IRQ_EN
    irq_take = irq_req && (state_nxt == FETCH1) && (state != FETCH1) && !redirect && !pend;
    if (irq_take) state_nxt = ISSUE;
`endif
  end

  always_comb begin
    imem_req = 1'b0;
    ir_valid = 1'b0;
    case (state)
      FETCH1, FETCH2, SKIP1, SKIP2: imem_req = 1'b1;
      ISSUE:                        ir_valid = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;
`ifdef OPSEQ_IRQ_EN
  assign irq_ack = irq_take;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
      ir      <= '0;
      ir_k    <= '0;
      ir_pc   <= '0;
      ir_two  <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      pend    <= pend_nxt;
      pend_pc <= pend_pc_nxt;
      if (cap_w1) begin
        ir     <= imem_rdata;
        ir_pc  <= pc;
        ir_k   <= '0;
        ir_two <= 1'b0;
      end
      if (cap_w2) begin
        ir_k   <= imem_rdata;
        ir_two <= 1'b1;
      end
`ifdef OPSEQ_IRQ_EN
      // ir_pc is biased back by two so execute pushes ir_pc+2 == the interrupted pc
      if (irq_take) begin
        ir     <= CALL_OP;
        ir_k   <= IRQ_BASE + {10'b0, irq_vec, 1'b0};
        ir_two <= 1'b1;
        ir_pc  <= pc_nxt - PC_TWO;
      end
`endif
    end
  end

endmodule

// File: tb/tb_op_fetch_seq.sv
// Scoreboard bench for op_fetch_seq: random memory latency, random accept/skip/redirect, async resets.
module tb_op_fetch_seq;
  localparam int          PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir, ir_k, ir_pc;
  logic        ir_two, ir_valid;
  logic        ex_ready, ex_skip, redirect;
  logic [15:0] redirect_pc;

  op_fetch_seq #(.PC_W(PC_W), .RESET_PC(RESET_PC), .IRQ_BASE(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_k(ir_k), .ir_pc(ir_pc), .ir_two(ir_two), .ir_valid(ir_valid),
    .ex_ready(ex_ready), .ex_skip(ex_skip), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] ir_k;
    logic [15:0] ir_pc;
    logic        two;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [0:65535];
  logic [15:0] cur_pc;
  int          vectors = 0;
  int          miscompares = 0;
  int          accepts = 0;
  bit          run_en = 1'b0;
  bit          timed_out = 1'b0;

  function automatic bit two_word(input logic [15:0] w);
    return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
  endfunction

  function automatic exp_t model_at(input logic [15:0] a);
    exp_t e;
    e.ir    = mem[a];
    e.two   = two_word(mem[a]);
    e.ir_k  = e.two ? mem[a + 16'd1] : 16'h0000;
    e.ir_pc = a;
    return e;
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] a);
    return two_word(mem[a]) ? a + 16'd2 : a + 16'd1;
  endfunction

  function automatic logic [15:0] gen_word();
    logic [15:0] x = 16'($urandom);
    int          r = int'($urandom_range(0, 9));
    if (r < 2) return 16'h940C | (x & 16'h01F3);
    if (r < 3) return 16'h9000 | (x & 16'h03F0);
    return x;
  endfunction

  function automatic logic [15:0] pick_target();
    int r = int'($urandom_range(0, 9));
    if (r < 5) return 16'($urandom_range(0, 40));
    if (r < 7) return 16'hFFFD + 16'($urandom_range(0, 2));
    if (r < 8) return 16'h0123;
    return 16'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req",  {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", {16'b0, imem_addr}, {16'b0, RESET_PC});
    chk("rst_ir",        {16'b0, ir}, 32'd0);
    chk("rst_ir_k",      {16'b0, ir_k}, 32'd0);
    chk("rst_ir_pc",     {16'b0, ir_pc}, 32'd0);
    chk("rst_ir_two",    {31'b0, ir_two}, 32'd0);
    chk("rst_ir_valid",  {31'b0, ir_valid}, 32'd0);
    exp_q.delete();
    cur_pc = RESET_PC;
    exp_q.push_back(model_at(RESET_PC));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // memory responder: random 0..3 cycle ack latency; stale ack driven during reset
  initial begin : responder
    int          wait_n;
    bit          busy;
    logic [15:0] held;
    imem_ack = 1'b0; imem_rdata = 16'h0; busy = 1'b0; wait_n = 0; held = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        imem_ack = 1'b1; imem_rdata = 16'hDEAD; busy = 1'b0;
        continue;
      end
      if (imem_ack) busy = 1'b0;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (busy) chk("addr_hold", {16'b0, imem_addr}, {16'b0, held});
        else begin
          busy = 1'b1; held = imem_addr; wait_n = int'($urandom_range(0, 3));
        end
        if (wait_n == 0) begin
          imem_ack = 1'b1; imem_rdata = mem[imem_addr];
        end else wait_n--;
      end
    end
  end

  // execute-side stimulus; pushes the expected next issue into the scoreboard
  initial begin : exec_drv
    logic [15:0] nxt;
    ex_ready = 1'b0; ex_skip = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    forever begin
      @(posedge clk); #1;
      ex_ready = 1'b0; ex_skip = 1'b0; redirect = 1'b0;
      if (!rst_n || !run_en) continue;
      if (ir_valid) begin
        if (accepts < 5) begin
          ex_ready = 1'b1;
          ex_skip  = (accepts == 3);
        end else begin
          ex_ready = ($urandom_range(0, 99) < 55);
          ex_skip  = ($urandom_range(0, 99) < 30);
          redirect = ($urandom_range(0, 99) < 10);
        end
        if (redirect) begin
          redirect_pc = pick_target();
          cur_pc = redirect_pc;
          exp_q.push_back(model_at(cur_pc));
        end else if (ex_ready) begin
          accepts++;
          nxt = next_pc(cur_pc);
          if (ex_skip) nxt = next_pc(nxt);
          cur_pc = nxt;
          exp_q.push_back(model_at(cur_pc));
        end
      end else begin
        ex_ready = ($urandom_range(0, 99) < 50);
        ex_skip  = ($urandom_range(0, 99) < 50);
        if (accepts >= 5 && $urandom_range(0, 99) < 6) begin
          redirect = 1'b1;
          redirect_pc = pick_target();
          cur_pc = redirect_pc;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          exp_q.push_back(model_at(cur_pc));
        end
      end
    end
  end

  // monitor: checks each newly presented instruction and stability while held
  initial begin : monitor
    bit   fresh;
    int   idle_cyc;
    exp_t e;
    fresh = 1'b1; idle_cyc = 0; e = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fresh = 1'b1; idle_cyc = 0;
        continue;
      end
      if (ir_valid) begin
        idle_cyc = 0;
        chk("no_req_in_issue", {31'b0, imem_req}, 32'd0);
        if (fresh) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_issue: got ir=%h ir_pc=%h, expected no instruction", ir, ir_pc);
          end else begin
            e = exp_q.pop_front();
            chk("ir",     {16'b0, ir},    {16'b0, e.ir});
            chk("ir_k",   {16'b0, ir_k},  {16'b0, e.ir_k});
            chk("ir_pc",  {16'b0, ir_pc}, {16'b0, e.ir_pc});
            chk("ir_two", {31'b0, ir_two}, {31'b0, e.two});
          end
          fresh = 1'b0;
        end else begin
          chk("hold_ir_pc", {ir, ir_pc}, {e.ir, e.ir_pc});
          chk("hold_ir_k",  {15'b0, ir_two, ir_k}, {15'b0, e.two, e.ir_k});
        end
        if (ex_ready || redirect) fresh = 1'b1;
      end else begin
        idle_cyc++;
        if (idle_cyc == 200) begin
          vectors++; miscompares++; timed_out = 1'b1;
          $display("FAIL issue_timeout: got no ir_valid for %0d cycles, expected an issue", idle_cyc);
        end
      end
    end
  end

  initial begin : main
    int cyc;
    for (int i = 0; i < 65536; i++) mem[i] = gen_word();
    mem[0] = 16'h0000; mem[1] = 16'h0001;
    mem[2] = 16'h940C; mem[3] = 16'h0040;
    mem[4] = 16'h1000; mem[5] = 16'h9200; mem[6] = 16'h0100; mem[7] = 16'h0000;
    cur_pc = RESET_PC;
    exp_q.push_back(model_at(RESET_PC));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    run_en = 1'b1;
    for (int seg = 0; seg < 4; seg++) begin
      cyc = 0;
      while (accepts < (seg + 1) * 80 && cyc < 5000 && !timed_out) begin
        @(posedge clk); cyc++;
      end
      if (cyc >= 5000) begin
        vectors++; miscompares++;
        $display("FAIL segment_budget: got %0d accepts, expected %0d", accepts, (seg + 1) * 80);
      end
      if (seg == 3) begin
        cyc = 0;
        forever begin
          @(posedge clk); #2;
          cyc++;
          if ((imem_req && !ir_valid && two_word(ir) && imem_addr == ir_pc + 16'd1) || cyc >= 3000) break;
        end
        if (cyc >= 3000) begin
          vectors++; miscompares++;
          $display("FAIL fetch2_wait: got no second-word fetch in %0d cycles, expected one", cyc);
        end
        #1 reset_now();
      end else begin
        @(posedge clk); #3;
        reset_now();
      end
    end
    cyc = 0;
    begin
      int target = accepts + 20;
      while (accepts < target && cyc < 2000 && !timed_out) begin
        @(posedge clk); cyc++;
      end
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
